// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default line settings and frame shape.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115200;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP1 = 3'd3,
    ST_STOP2 = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// End-of-bit strobe: a free-running bit-period counter with synchronous clear.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Wrap at the last cycle of a bit so the count never exceeds CLKS_PER_BIT-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N2 UART transmitter: start bit, eight data bits LSB first, two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE    = DEF_BAUD_RATE,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [2:0] state
);

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 baud_clr;
  logic                 done;

  // The counter is held in IDLE and cleared on every state change, so each
  // state starts a full bit period from zero.
  assign baud_clr = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  // Next-state, shift register and bit index; unknown codes fall back to IDLE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          shreg_d = data_in;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP1;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          end
        end
      end
      ST_STOP1: begin
        if (tick) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (tick) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so the registered tx changes on
  // the same edge as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State, data and line registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_done  = done;
  assign state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames, with a line receiver feeding a scoreboard.
module tb_uart_tx;

  localparam int unsigned CPB = 50_000_000 / 115200;  // 434

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       tx_start;
  logic       tx;
  logic       tx_ready;
  logic       tx_done;
  logic [2:0] state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned rx_frames = 0;
  logic [7:0]  exp_q[$];

  uart_tx #(
    .CLK_FREQ  (50_000_000),
    .BAUD_RATE (115200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic frame_check(input logic [10:0] w);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_unexpected: got frame 0x%0h, expected no frame", w);
    end else begin
      e = exp_q.pop_front();
      check("rx_data", 32'(w[8:1]), 32'(e));
      check("rx_start_bit", 32'(w[0]), 32'd0);
      check("rx_stop_bits", 32'(w[10:9]), 32'd3);
      rx_frames++;
    end
  endtask

  // Line receiver: samples the middle of each bit, resyncs on reset.
  logic        r_busy = 1'b0;
  int unsigned r_cnt  = 0;
  logic [10:0] r_sh   = '0;
  always @(posedge clk) begin
    logic [10:0] w;
    #1;
    if (rst) begin
      r_busy <= 1'b0;
    end else if (!r_busy) begin
      if (tx === 1'b0) begin
        r_busy <= 1'b1;
        r_cnt  <= 1;
        r_sh   <= '0;
      end
    end else begin
      r_cnt <= r_cnt + 1;
      if (r_cnt % CPB == CPB / 2) begin
        if (r_cnt / CPB < 10) begin
          r_sh[r_cnt / CPB] <= tx;
        end else begin
          w = r_sh;
          w[10] = tx;
          r_busy <= 1'b0;
          frame_check(w);
        end
      end
    end
  end

  task automatic wait_ready();
    int unsigned k = 0;
    while (tx_ready !== 1'b1 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (tx_ready !== 1'b1) timeout("wait_ready");
  endtask

  task automatic send(input logic [7:0] b, input bit expect_rx);
    wait_ready();
    data_in  = b;
    tx_start = 1'b1;
    if (expect_rx) exp_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned k = 0;
    while (tx_done !== 1'b1 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (tx_done !== 1'b1) timeout("wait_done");
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int unsigned k = 0;
    while (state !== s && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (state !== s) timeout("wait_state");
  endtask

  task automatic wait_rx(input int unsigned n);
    int unsigned k = 0;
    while (rx_frames < n && k < 12000) begin
      @(negedge clk);
      k++;
    end
    if (rx_frames < n) timeout("wait_rx");
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0]  vec [5];
    logic [10:0] pat;
    int unsigned dones;
    int unsigned done_at;
    int unsigned k;

    vec = '{8'h00, 8'h07, 8'hAA, 8'hFF, 8'hA5};

    // Reset, with tx_start high to show reset wins
    rst = 1'b1; tx_start = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    tx_start = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0; tx_start = 1'b0;
    @(negedge clk);
    check("idle_state", 32'(state), 32'd0);

    // 0x55: exact bit timing and single done pulse
    wait_ready();
    data_in = 8'h55; tx_start = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    tx_start = 1'b0; data_in = 8'h00;
    dones = 0; done_at = 0; pat = '0;
    for (int i = 0; i <= 4775; i++) begin
      if (i == 0) begin
        check("start_tx_low", 32'(tx), 32'd0);
        check("start_state", 32'(state), 32'd1);
        check("start_not_ready", 32'(tx_ready), 32'd0);
      end
      if (i % CPB == CPB / 2 && i / CPB < 11) pat[i / CPB] = tx;
      if (i == 433)  check("bit0_edge_before", 32'(tx), 32'd0);
      if (i == 434)  begin
        check("bit0_edge_tx", 32'(tx), 32'd1);
        check("bit0_edge_state", 32'(state), 32'd2);
      end
      if (i == 3905) check("data_last_state", 32'(state), 32'd2);
      if (i == 3906) check("stop1_state", 32'(state), 32'd3);
      if (i == 4340) check("stop2_state", 32'(state), 32'd4);
      if (tx_done === 1'b1) begin
        dones++;
        done_at = i;
      end
      if (i == 4774) begin
        check("post_frame_state", 32'(state), 32'd0);
        check("post_frame_ready", 32'(tx_ready), 32'd1);
        check("post_frame_tx", 32'(tx), 32'd1);
      end
      @(negedge clk);
    end
    check("pattern_55", 32'(pat), 32'h6AA);
    check("done_count_55", dones, 1);
    check("done_cycle_55", done_at, 4773);
    wait_rx(1);

    // Loopback bytes
    for (int j = 0; j < 5; j++) begin
      send(vec[j], 1'b1);
      wait_done();
    end
    wait_rx(6);

    // tx_start held: three frames with one idle cycle between
    wait_ready();
    data_in = 8'h12; tx_start = 1'b1; exp_q.push_back(8'h12);
    for (int f = 0; f < 3; f++) begin
      k = 0;
      @(negedge clk);
      while (tx_done !== 1'b1 && k < 6000) begin
        @(negedge clk);
        k++;
      end
      if (tx_done !== 1'b1) timeout("b2b_done");
      if (f == 0) begin
        data_in = 8'h34; exp_q.push_back(8'h34);
      end else if (f == 1) begin
        data_in = 8'h56; exp_q.push_back(8'h56);
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
      check("b2b_gap_state", 32'(state), 32'd0);
      check("b2b_gap_tx", 32'(tx), 32'd1);
      @(negedge clk);
      if (f < 2) begin
        check("b2b_restart_state", 32'(state), 32'd1);
        check("b2b_restart_tx", 32'(tx), 32'd0);
      end else begin
        check("b2b_stays_idle", 32'(state), 32'd0);
      end
    end
    wait_rx(9);

    // Start request during DATA is ignored
    send(8'h3C, 1'b1);
    wait_state(3'd2);
    repeat (100) @(negedge clk);
    check("busy_not_ready", 32'(tx_ready), 32'd0);
    data_in = 8'hBD; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6000; i++) begin
      if (tx_done === 1'b1) dones++;
      @(negedge clk);
    end
    check("ignore_done_count", dones, 1);
    check("ignore_idle_after", 32'(state), 32'd0);
    wait_rx(10);

    // Reset at bit 4 aborts the frame
    send(8'hF0, 1'b0);
    wait_state(3'd2);
    repeat (4 * CPB + 50) @(negedge clk);
    check("abort_in_data", 32'(state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_state", 32'(state), 32'd0);
    check("abort_ready", 32'(tx_ready), 32'd1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_done === 1'b1) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    send(8'h99, 1'b1);
    wait_done();
    wait_rx(11);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
